round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of requesters, at least 1.
REQ-002 SHALL have parameter SPLIT, default 4: tree split factor passed to the internal encoders.
REQ-003 SHALL have parameter IMPLEMENTATION, default 0: encoder implementation select passed to the internal encoders.
REQ-004 SHALL have parameter HOLD_MAX, default 8: maximum grant cycles while others wait; 0 disables preemption.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port req, input, WIDTH bits: per-requester request, level-held by the requester while it needs the resource.
REQ-008 SHALL have port gnt, output, WIDTH bits: registered one-hot grant, or all zero.
REQ-009 SHALL have port gnt_vld, output, 1 bit: registered; equals |gnt.
REQ-010 SHALL have port gnt_idx, output, $clog2(WIDTH) bits: registered index of the granted bit; meaningful only while gnt_vld=1.

Function
REQ-011 SHALL implement a 2-state FSM, IDLE and GRANT, with a pointer ptr (last winner index) and a hold counter cnt.
REQ-012 SHALL, in any cycle needing arbitration, select the lowest set index of req & (bits above ptr); if that is empty, the lowest set index of req.
REQ-013 SHALL arbitrate in IDLE whenever |req=1, then register gnt/gnt_idx/gnt_vld at the next edge, go to GRANT, set ptr to the winner and clear cnt (one-cycle request-to-grant latency).
REQ-014 SHALL hold the grant in GRANT while req[gnt_idx]=1 and no preemption applies; cnt increments each held cycle and saturates at HOLD_MAX-1.
REQ-015 SHALL re-arbitrate over req & ~gnt with no idle bubble when req[gnt_idx]=0 in GRANT: at the next edge gnt moves to the winner, or, if none, gnt clears and the FSM goes to IDLE.
REQ-016 SHALL preempt when HOLD_MAX>0, cnt==HOLD_MAX-1 and (req & ~gnt)!=0: at the next edge gnt moves to the winner of req & ~gnt, so a holder keeps the grant exactly HOLD_MAX cycles.
REQ-017 SHALL keep the grant with cnt saturated when the holder is the only requester at expiry; preemption then occurs on the first cycle another req appears.
REQ-018 SHALL treat a holder release coinciding with expiry as a normal release (REQ-015).
REQ-019 SHALL never assert more than one gnt bit, and SHALL never grant a requester whose req was 0 in the arbitration cycle.
REQ-020 SHALL, for WIDTH=1, degenerate to gnt=req delayed one cycle; preemption never fires.

Reset
REQ-021 SHALL, on rst_n=0 (asynchronous, including mid-grant), immediately set gnt=0, gnt_vld=0, gnt_idx=0, FSM=IDLE, cnt=0 and ptr=WIDTH-1, so requester 0 has first priority.
REQ-022 SHALL make the first grant no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-023 SHALL place the FSM state enum and the index-width function/typedef in shared package arbiter_pkg.
REQ-024 SHALL build the masked and unmasked selections from two instances of the existing priority_encoder_tree sub-module (WIDTH, SPLIT, IMPLEMENTATION passed through), the second one's enc_vld selecting between them.
REQ-025 SHALL keep all outputs registered with no combinational path from req to gnt.

Verification (WIDTH=16, HOLD_MAX=4)
REQ-026 SHALL verify: after reset, req=16'h0001 -> gnt=16'h0001, gnt_idx=0 one cycle later; req drops -> gnt=0, state IDLE.
REQ-027 SHALL verify: req=16'h8421 held, each holder dropping after 1 cycle -> grant order idx 0,5,10,15,0 with no idle cycles.
REQ-028 SHALL verify: req[3] held continuously, req[7] raised -> gnt[3] for exactly 4 cycles, then gnt=16'h0080.
REQ-029 SHALL verify: only req[2] held for 20 cycles -> gnt=16'h0004 throughout; req[9] raised -> gnt=16'h0200 one cycle later.
REQ-030 SHALL verify: rst_n pulsed low mid-grant -> outputs 0 without a clk edge; with req=16'hFFFF after reset -> first gnt_idx=0.
REQ-031 SHALL check every cycle with assertions: $onehot0(gnt), gnt_vld==|gnt, and gnt_vld implies gnt[gnt_idx]=1.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter and its priority encoders.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder_tree.sv
// Lowest-set-index priority encoder; IMPLEMENTATION 0 scans SPLIT-wide groups, otherwise a flat scan.
module priority_encoder_tree
  import arbiter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0]        enc_in,
  output logic [idx_w(WIDTH)-1:0] enc_idx,
  output logic                    enc_vld
);

  localparam int IW     = idx_w(WIDTH);
  localparam int SP     = (SPLIT < 1) ? 1 : SPLIT;
  localparam int GROUPS = (WIDTH + SP - 1) / SP;
  localparam int PW     = GROUPS * SP;

  logic [PW-1:0] w_pad;

  assign w_pad = PW'(enc_in);

  always_comb begin
    logic          grp_any;
    logic [IW-1:0] grp_idx;
    grp_any = 1'b0;
    grp_idx = '0;
    enc_idx = '0;
    enc_vld = 1'b0;
    if (IMPLEMENTATION == 0) begin
      // Groups are scanned high to low so the lowest non-empty group wins.
      for (int g = GROUPS - 1; g >= 0; g--) begin
        grp_any = 1'b0;
        grp_idx = '0;
        for (int b = SP - 1; b >= 0; b--) begin
          if (w_pad[g*SP+b]) begin
            grp_any = 1'b1;
            grp_idx = IW'(g*SP+b);
          end
        end
        if (grp_any) begin
          enc_vld = 1'b1;
          enc_idx = grp_idx;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (enc_in[i]) begin
          enc_vld = 1'b1;
          enc_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter with a hold limit that preempts a long-running holder.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0,
  parameter int HOLD_MAX       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        req,
  output logic [WIDTH-1:0]        gnt,
  output logic                    gnt_vld,
  output logic [idx_w(WIDTH)-1:0] gnt_idx
);

  localparam int             IW      = idx_w(WIDTH);
  localparam int             CW      = idx_w((HOLD_MAX > 1) ? HOLD_MAX : 2);
  localparam logic [CW-1:0]  CNT_MAX = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
  localparam bit             PREEMPT = (HOLD_MAX > 0) && (WIDTH > 1);

  arb_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_gnt, w_gnt_nxt;
  logic             r_gnt_vld, w_gnt_vld_nxt;
  logic [IW-1:0]    r_gnt_idx, w_gnt_idx_nxt;
  logic [IW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;

  logic [WIDTH-1:0] w_cand, w_mask, w_masked;
  logic [IW-1:0]    w_any_idx, w_msk_idx, w_win_idx;
  logic             w_any_vld, w_msk_vld;
  logic             w_hold, w_others, w_expired;

  // While granting, the current holder is excluded so a release or preemption never re-picks it.
  assign w_cand = (r_state == IDLE) ? req : (req & ~r_gnt);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) w_mask[i] = (i > int'(r_ptr));
  end

  assign w_masked = w_cand & w_mask;

  priority_encoder_tree #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_enc_any (
    .enc_in(w_cand), .enc_idx(w_any_idx), .enc_vld(w_any_vld)
  );

  priority_encoder_tree #(
    .WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)
  ) u_enc_msk (
    .enc_in(w_masked), .enc_idx(w_msk_idx), .enc_vld(w_msk_vld)
  );

  assign w_win_idx = w_msk_vld ? w_msk_idx : w_any_idx;
  assign w_hold    = req[r_gnt_idx];
  assign w_others  = |(req & ~r_gnt);
  assign w_expired = PREEMPT && (r_cnt == CNT_MAX);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_vld_nxt = r_gnt_vld;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    if ((r_state == IDLE) || !w_hold || (w_expired && w_others)) begin
      if (w_any_vld) begin
        w_state_nxt            = GRANT;
        w_gnt_nxt              = '0;
        w_gnt_nxt[w_win_idx]   = 1'b1;
        w_gnt_vld_nxt          = 1'b1;
        w_gnt_idx_nxt          = w_win_idx;
        w_ptr_nxt              = w_win_idx;
        w_cnt_nxt              = '0;
      end else begin
        w_state_nxt   = IDLE;
        w_gnt_nxt     = '0;
        w_gnt_vld_nxt = 1'b0;
      end
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
      r_ptr     <= IW'(WIDTH - 1);
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = r_gnt_vld;
  assign gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter with WIDTH=16, HOLD_MAX=4.
module tb_round_robin_arbiter;
  import arbiter_pkg::*;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  idx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic [15:0] gnt;
  logic        gnt_vld;
  logic [3:0]  gnt_idx;
  logic [15:0] prev_req;

  int checks = 0;
  int errors = 0;
  vec_t tab[$];

  always #5 clk = ~clk;

  round_robin_arbiter #(
    .WIDTH(16), .SPLIT(4), .IMPLEMENTATION(0), .HOLD_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx)
  );

  // Request vector seen by the DUT at the most recent rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_req <= '0;
    else        prev_req <= req;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(gnt) || (gnt_vld !== (|gnt)) || (gnt_vld && !gnt[gnt_idx]) ||
          ((gnt & prev_req) !== gnt)) begin
        errors++;
        $display("FAIL invariant t=%0t: gnt=%h vld=%0b idx=%0d prev_req=%h; need onehot0, vld==|gnt, gnt[idx], gnt within req",
                 $time, gnt, gnt_vld, gnt_idx, prev_req);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] eg, input logic [3:0] ei, input bit strict);
    logic ev;
    ev = |eg;
    checks++;
    if (gnt !== eg || gnt_vld !== ev || ((ev || strict) && gnt_idx !== ei)) begin
      errors++;
      $display("FAIL %s: got gnt=%h vld=%0b idx=%0d, want gnt=%h vld=%0b idx=%0d",
               nm, gnt, gnt_vld, gnt_idx, eg, ev, ei);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic r, input logic [15:0] q, input logic [15:0] g, input logic [3:0] i);
    vec_t v;
    v.rst = r; v.req = q; v.gnt = g; v.idx = i;
    tab.push_back(v);
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Rotation 0,5,10,15,0 with each holder dropping after one cycle.
    add(1, 16'h8421, 16'h0001, 4'd0);
    add(0, 16'h8420, 16'h0020, 4'd5);
    add(0, 16'h8400, 16'h0400, 4'd10);
    add(0, 16'h8001, 16'h8000, 4'd15);
    add(0, 16'h0421, 16'h0001, 4'd0);
    add(0, 16'h0000, 16'h0000, 4'd0);
    // Holder 3 preempted after exactly 4 cycles by 7, then 7 preempted back to 3.
    add(0, 16'h0008, 16'h0008, 4'd3);
    for (int k = 0; k < 3; k++) add(0, 16'h0088, 16'h0008, 4'd3);
    for (int k = 0; k < 4; k++) add(0, 16'h0088, 16'h0080, 4'd7);
    add(0, 16'h0088, 16'h0008, 4'd3);
    add(0, 16'h0000, 16'h0000, 4'd0);

    rst_n = 1'b0;
    req   = '0;
    #12;
    chk("reset_outputs", 16'h0000, 4'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    req = 16'h0001;
    tick();
    chk("single_grant", 16'h0001, 4'd0, 1'b0);
    req = 16'h0000;
    tick();
    chk("single_release", 16'h0000, 4'd0, 1'b0);
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL state_idle: got %0d, want %0d", dut.r_state, IDLE);
    end

    foreach (tab[n]) begin
      if (tab[n].rst) do_reset();
      req = tab[n].req;
      tick();
      chk($sformatf("table_row_%0d", n), tab[n].gnt, tab[n].idx, 1'b0);
    end

    // Sole requester keeps the grant past expiry, then yields at once to a newcomer.
    req = 16'h0004;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("sole_hold_%0d", k), 16'h0004, 4'd2, 1'b0);
    end
    req = 16'h0204;
    tick();
    chk("late_preempt", 16'h0200, 4'd9, 1'b0);
    req = 16'h0000;
    tick();
    chk("late_release", 16'h0000, 4'd0, 1'b0);

    // Asynchronous reset mid-grant, then all requesters contend.
    req = 16'h0010;
    tick();
    chk("pre_reset_grant", 16'h0010, 4'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 16'h0000, 4'd0, 1'b1);
    req = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("no_grant_before_edge", 16'h0000, 4'd0, 1'b1);
    tick();
    chk("post_reset_first", 16'h0001, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("all_hold_%0d", k), 16'h0001, 4'd0, 1'b0);
    end
    tick();
    chk("all_rotate", 16'h0002, 4'd1, 1'b0);
    req = 16'h0000;
    tick();
    chk("final_release", 16'h0000, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
